mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
Multi-cycle multiply/divide sequencer. It computes 32x32 products and quotient/remainder by iterating shift-add and restoring-subtract steps on the CPU's single 32-bit ALU (ALU32) over its shared A/B/AluOp/S/cout ports.
- The parent multiplexes ALU inputs to this block while busy=1.
- Results go to the HI/LO pair: lo = product low word or quotient; hi = product high word or remainder.

Parameters:
- XLEN, 32, operand width (only 32 is supported).
- CNT_W, 5, iteration counter width; the counter counts XLEN-1 down to 0.

Ports:
- clk  in  1  system clock. Single clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- src_a  in  32  multiplicand or dividend.
- src_b  in  32  multiplier or divisor.
- busy  out  1  high in every state except IDLE; the parent gives this block the ALU while it is high.
- done  out  1  one-cycle pulse when hi/lo are valid.
- div0  out  1  divisor was zero; valid with done and held until the next start.
- hi  out  32  high word or remainder; held until the next start.
- lo  out  32  low word or quotient; held until the next start.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_op  out  4  ALU opcode.
- alu_s  in  32  ALU result.
- alu_cout  in  1  ALU carry out; on SUB, 1 means no borrow.

Behaviour:
- Reset: state=IDLE; busy, done, div0=0; hi, lo, internal registers=0. A reset mid-operation aborts immediately and no done is produced.
- States: IDLE -> [NEGA -> NEGB, signed only] -> ITER (32 cycles) -> [FIX1 -> FIX2, signed only] -> DONE -> IDLE.
- IDLE: when start=1, latch op, src_a, src_b. Initialise:
  - multiply: hi=0, lo=src_b, m=src_a.
  - divide: hi=0, lo=src_a, m=src_b; div0 = (src_b==0).
  - cnt=31.
- start while busy is ignored. No queueing.
- Default ALU drive in IDLE/DONE, and in a NEG/FIX cycle that makes no change: alu_op=ADD (0010), alu_a=alu_b=0.
- ITER, multiply: alu_op=ADD, alu_a=hi, alu_b = lo[0] ? m : 0. Next hi={alu_cout, alu_s[31:1]}; next lo={alu_s[0], lo[31:1]}.
- ITER, divide: sh={hi[30:0], lo[31]}; alu_op=SUB (0110), alu_a=sh, alu_b=m.
  - q = hi[31] | alu_cout.
  - next hi = q ? alu_s : sh; next lo={lo[30:0], q}.
- ITER: cnt decrements each cycle; leave ITER after the cycle with cnt==0.
- DONE: done=1 for exactly one cycle, then IDLE.
- Fixed latency: start sampled at edge E0; done high in the cycle after edge E33 (unsigned) or E37 (signed). Latency does not depend on the data.
- Divide by zero needs no special path: the algorithm yields quotient=FFFFFFFF and remainder=dividend, and div0=1.
- Width: all ALU arithmetic is modulo 2^32. 0x80000000 negates to itself and is then treated as an unsigned magnitude.

Optional Feature:
Macro MDU_SIGNED_EN.
- Defined:
  - NEGA: if src_a[31], m/lo ← 0-x via SUB with alu_a=0.
  - NEGB: same for the other operand.
  - Record sign flags sa, sb.
  - Multiply fix-up, when sa^sb:
    - FIX1: lo ← 0-lo (SUB); record lz=(lo==0).
    - FIX2: hi ← lz ? 0-hi (SUB) : ~hi (NOR 1100, alu_a=alu_b=hi).
  - Divide fix-up:
    - FIX1: if sa^sb, lo ← 0-lo.
    - FIX2: if sa, hi ← 0-hi.
  - Otherwise FIX1/FIX2 leave registers unchanged and use the default ALU drive.
- Not defined: op[1] is ignored, MULT/DIV execute as MULTU/DIVU, the NEG/FIX states do not exist, and latency is always 33.

Decomposition:
- Package mdu_pkg holds:
  - op encodings (OP_MULTU, OP_DIVU, OP_MULT, OP_DIV);
  - ALU opcode constants (ALU_ADD=0010, ALU_SUB=0110, ALU_NOR=1100);
  - the state enum.
- No sub-module. ALU32 stays external; the parent instantiates it and muxes its inputs between the datapath and this block using busy.

Test Plan:
- MULTU 7*6 → hi=0, lo=0000002A; done exactly 33 cycles after start; busy high throughout; ALU ops observed are ADD only.
- MULTU FFFFFFFF*FFFFFFFF → hi=FFFFFFFE, lo=00000001. Then DIVU 100/7 → lo=0000000E, hi=00000002, div0=0.
- DIVU 12345678/0 → lo=FFFFFFFF, hi=12345678, div0=1.
- With MDU_SIGNED_EN:
  - MULT -3*5 → hi=FFFFFFFF, lo=FFFFFFF1, latency 37.
  - DIV -7/2 → lo=FFFFFFFD, hi=FFFFFFFF.
  - MULT 0*-1 → hi=lo=0 (exercises the lz path).
- start pulsed during ITER with other operands → ignored; original result delivered; a following start in IDLE is accepted.
- rst asserted mid-ITER → next cycle IDLE with busy=0, hi=lo=0, and no done pulse. A fresh MULTU 2*3 then gives lo=6.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op/ALU encodings and state type shared by the mdu_seq slice
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

`ifdef MDU_SIGNED_EN
  typedef enum logic [2:0] {S_IDLE, S_NEGA, S_NEGB, S_ITER, S_FIX1, S_FIX2, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ITER, S_DONE} state_t;
`endif

endpackage

// File: rtl/mdu_seq_if.sv
// rtl/mdu_seq_if.sv - request/result handshake and shared-ALU port bundle of mdu_seq
interface mdu_seq_if;
  import mdu_pkg::*;

  logic                start;
  logic [1:0]          op;
  logic [MDU_XLEN-1:0] src_a;
  logic [MDU_XLEN-1:0] src_b;
  logic                busy;
  logic                done;
  logic                div0;
  logic [MDU_XLEN-1:0] hi;
  logic [MDU_XLEN-1:0] lo;
  logic [MDU_XLEN-1:0] alu_a;
  logic [MDU_XLEN-1:0] alu_b;
  logic [3:0]          alu_op;
  logic [MDU_XLEN-1:0] alu_s;
  logic                alu_cout;

  modport master (
    output start, op, src_a, src_b, alu_s, alu_cout,
    input  busy, done, div0, hi, lo, alu_a, alu_b, alu_op
  );

  modport slave (
    input  start, op, src_a, src_b, alu_s, alu_cout,
    output busy, done, div0, hi, lo, alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multi-cycle multiply/divide sequencer driving the shared ALU32
// Signed MULT/DIV (NEG/FIX states) are built only when MDU_SIGNED_EN is defined.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic      clk,
  input logic      rst,
  mdu_seq_if.slave bus
);

  state_t            state, state_n;
  logic              is_div;
  logic              div0_r;
  logic              done_r;
  logic [XLEN-1:0]   hi_r, lo_r, m_r;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   sh;
  logic              q;
  logic [XLEN-1:0]   alu_a, alu_b;
  logic [3:0]        alu_op;
`ifdef MDU_SIGNED_EN
  logic              is_sgn, sa, sb, lz;
`endif

  // Restoring divide: a set hi[31] means the shifted value already exceeds any divisor.
  assign sh = {hi_r[XLEN-2:0], lo_r[XLEN-1]};
  assign q  = hi_r[XLEN-1] | bus.alu_cout;

  always_comb begin
    state_n = state;
    alu_op  = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef MDU_SIGNED_EN
          state_n = bus.op[1] ? S_NEGA : S_ITER;
`else
          state_n = S_ITER;
`endif
        end
      end
`ifdef MDU_SIGNED_EN
      S_NEGA: begin
        if (sa) begin
          alu_op = ALU_SUB;
          alu_b  = is_div ? lo_r : m_r;
        end
        state_n = S_NEGB;
      end
      S_NEGB: begin
        if (sb) begin
          alu_op = ALU_SUB;
          alu_b  = is_div ? m_r : lo_r;
        end
        state_n = S_ITER;
      end
`endif
      S_ITER: begin
        if (is_div) begin
          alu_op = ALU_SUB;
          alu_a  = sh;
          alu_b  = m_r;
        end else begin
          alu_a  = hi_r;
          alu_b  = lo_r[0] ? m_r : '0;
        end
        if (cnt == '0) begin
`ifdef MDU_SIGNED_EN
          state_n = is_sgn ? S_FIX1 : S_DONE;
`else
          state_n = S_DONE;
`endif
        end
      end
`ifdef MDU_SIGNED_EN
      S_FIX1: begin
        if (sa ^ sb) begin
          alu_op = ALU_SUB;
          alu_b  = lo_r;
        end
        state_n = S_FIX2;
      end
      S_FIX2: begin
        // Negating a 64-bit product: the high word only takes the +1 carry when lo was zero.
        if (!is_div && (sa ^ sb)) begin
          if (lz) begin
            alu_op = ALU_SUB;
            alu_b  = hi_r;
          end else begin
            alu_op = ALU_NOR;
            alu_a  = hi_r;
            alu_b  = hi_r;
          end
        end else if (is_div && sa) begin
          alu_op = ALU_SUB;
          alu_b  = hi_r;
        end
        state_n = S_DONE;
      end
`endif
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      is_div <= 1'b0;
      div0_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      m_r    <= '0;
      cnt    <= '0;
`ifdef MDU_SIGNED_EN
      is_sgn <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      lz     <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      done_r <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            is_div <= bus.op[0];
            hi_r   <= '0;
            lo_r   <= bus.op[0] ? bus.src_a : bus.src_b;
            m_r    <= bus.op[0] ? bus.src_b : bus.src_a;
            div0_r <= bus.op[0] && (bus.src_b == '0);
            cnt    <= CNT_W'(XLEN - 1);
`ifdef MDU_SIGNED_EN
            is_sgn <= bus.op[1];
            sa     <= bus.op[1] & bus.src_a[XLEN-1];
            sb     <= bus.op[1] & bus.src_b[XLEN-1];
`endif
          end
        end
`ifdef MDU_SIGNED_EN
        S_NEGA: if (sa) begin
          if (is_div) lo_r <= bus.alu_s;
          else        m_r  <= bus.alu_s;
        end
        S_NEGB: if (sb) begin
          if (is_div) m_r  <= bus.alu_s;
          else        lo_r <= bus.alu_s;
        end
`endif
        S_ITER: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            hi_r <= q ? bus.alu_s : sh;
            lo_r <= {lo_r[XLEN-2:0], q};
          end else begin
            hi_r <= {bus.alu_cout, bus.alu_s[XLEN-1:1]};
            lo_r <= {bus.alu_s[0], lo_r[XLEN-1:1]};
          end
        end
`ifdef MDU_SIGNED_EN
        S_FIX1: if (sa ^ sb) begin
          lo_r <= bus.alu_s;
          lz   <= (lo_r == '0);
        end
        S_FIX2: if ((!is_div && (sa ^ sb)) || (is_div && sa)) begin
          hi_r <= bus.alu_s;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = done_r;
  assign bus.div0   = div0_r;
  assign bus.hi     = hi_r;
  assign bus.lo     = lo_r;
  assign bus.alu_a  = alu_a;
  assign bus.alu_b  = alu_b;
  assign bus.alu_op = alu_op;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq with an ALU32 model and arithmetic reference
module tb_mdu_seq;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;

`ifdef MDU_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  mdu_seq_if bus();

  mdu_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.alu_s    = '0;
    bus.alu_cout = 1'b0;
    case (bus.alu_op)
      ALU_ADD: {bus.alu_cout, bus.alu_s} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      ALU_SUB: {bus.alu_cout, bus.alu_s} = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
      ALU_NOR: bus.alu_s = ~(bus.alu_a | bus.alu_b);
      default: ;
    endcase
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        d0;
    int          lat;
  } vec_t;

  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r_hi, output logic [31:0] r_lo,
                                    output logic r_d0, output int r_lat);
    bit          sgn;
    longint      prod;
    logic [63:0] p;
    logic [31:0] ua, ub, uq, ur;
    sgn   = SIGNED_EN && op[1];
    r_lat = sgn ? 37 : 33;
    r_d0  = op[0] && (b == 32'h0);
    if (!op[0]) begin
      if (sgn) begin
        prod = longint'($signed(a)) * longint'($signed(b));
        p    = prod;
      end else begin
        p = {32'h0, a} * {32'h0, b};
      end
      r_hi = p[63:32];
      r_lo = p[31:0];
    end else begin
      ua   = (sgn && a[31]) ? -a : a;
      ub   = (sgn && b[31]) ? -b : b;
      uq   = (ub == 32'h0) ? 32'hFFFF_FFFF : ua / ub;
      ur   = (ub == 32'h0) ? ua : ua % ub;
      r_lo = (sgn && (a[31] ^ b[31])) ? -uq : uq;
      r_hi = (sgn && a[31]) ? -ur : ur;
    end
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int inject,
                        output logic [31:0] o_hi, output logic [31:0] o_lo, output logic o_d0,
                        output int lat, output bit busy_ok, output bit add_only, output bit pulse_ok);
    lat      = -1;
    busy_ok  = 1'b1;
    add_only = 1'b1;
    pulse_ok = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (!bus.busy) busy_ok = 1'b0;
    if (bus.alu_op != ALU_ADD) add_only = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (n == inject) begin
        bus.start = 1'b1;
        bus.op    = ~op;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
      end else if (n == inject + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = n;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.alu_op != ALU_ADD) add_only = 1'b0;
    end
    o_hi = bus.hi;
    o_lo = bus.lo;
    o_d0 = bus.div0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    pulse_ok = !bus.done && !bus.busy;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.div0} !== 3'b000 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy/done/div0=%b hi=%h lo=%h, required 000/0/0",
               {bus.busy, bus.done, bus.div0}, bus.hi, bus.lo);
    end
    tests_run++;
    if (bus.alu_op !== ALU_ADD || bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_alu: op=%h a=%h b=%h, required 2/0/0", bus.alu_op, bus.alu_a, bus.alu_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t        vecs[$];
    logic [31:0] g_hi, g_lo;
    logic        g_d0;
    int          lat;
    bit          busy_ok, add_only, pulse_ok;
    vecs.push_back('{OP_MULTU, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 33});
    vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 33});
    vecs.push_back('{OP_DIVU, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0, 33});
    vecs.push_back('{OP_DIVU, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 33});
`ifdef MDU_SIGNED_EN
    vecs.push_back('{OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 37});
    vecs.push_back('{OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 37});
    vecs.push_back('{OP_MULT, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 37});
`else
    vecs.push_back('{OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'h4, 32'hFFFF_FFF1, 1'b0, 33});
    vecs.push_back('{OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, 1'b0, 33});
`endif
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, g_hi, g_lo, g_d0, lat, busy_ok, add_only, pulse_ok);
      tests_run++;
      if (g_hi !== vecs[i].hi || g_lo !== vecs[i].lo || g_d0 !== vecs[i].d0) begin
        tests_failed++;
        $display("FAIL directed_%0d result: hi=%h lo=%h div0=%b, required hi=%h lo=%h div0=%b",
                 i, g_hi, g_lo, g_d0, vecs[i].hi, vecs[i].lo, vecs[i].d0);
      end
      tests_run++;
      if (lat != vecs[i].lat || !busy_ok || !pulse_ok) begin
        tests_failed++;
        $display("FAIL directed_%0d timing: latency=%0d busy_ok=%0d pulse_ok=%0d, required %0d/1/1",
                 i, lat, busy_ok, pulse_ok, vecs[i].lat);
      end
      if (vecs[i].op == OP_MULTU) begin
        tests_run++;
        if (!add_only) begin
          tests_failed++;
          $display("FAIL directed_%0d alu_ops: non-ADD op seen, required ADD only", i);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] g_hi, g_lo;
    logic        g_d0;
    int          lat;
    bit          busy_ok, add_only, pulse_ok;
    run_op(OP_DIVU, 32'hCAFE_0001, 32'h0, 0, g_hi, g_lo, g_d0, lat, busy_ok, add_only, pulse_ok);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (bus.hi !== 32'hCAFE_0001 || bus.lo !== 32'hFFFF_FFFF || bus.div0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold: hi=%h lo=%h div0=%b, required CAFE0001/FFFFFFFF/1", bus.hi, bus.lo, bus.div0);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, e_hi, e_lo, g_hi, g_lo;
    logic        e_d0, g_d0;
    int          e_lat, lat;
    bit          busy_ok, add_only, pulse_ok;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'h8000_0000 | 32'($urandom_range(0, 7));
        default: b = 32'($urandom);
      endcase
      ref_model(op, a, b, e_hi, e_lo, e_d0, e_lat);
      run_op(op, a, b, 0, g_hi, g_lo, g_d0, lat, busy_ok, add_only, pulse_ok);
      tests_run++;
      if (g_hi !== e_hi || g_lo !== e_lo || g_d0 !== e_d0 || lat != e_lat) begin
        tests_failed++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: hi=%h lo=%h div0=%b lat=%0d, required hi=%h lo=%h div0=%b lat=%0d",
                 i, op, a, b, g_hi, g_lo, g_d0, lat, e_hi, e_lo, e_d0, e_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, e_hi, e_lo, g_hi, g_lo;
    logic        e_d0, g_d0;
    int          e_lat, lat;
    bit          busy_ok, add_only, pulse_ok;
    a = $urandom;
    b = $urandom;
    ref_model(OP_MULTU, a, b, e_hi, e_lo, e_d0, e_lat);
    run_op(OP_MULTU, a, b, 10, g_hi, g_lo, g_d0, lat, busy_ok, add_only, pulse_ok);
    tests_run++;
    if (g_hi !== e_hi || g_lo !== e_lo || lat != e_lat) begin
      tests_failed++;
      $display("FAIL ignore_start: hi=%h lo=%h lat=%0d, required hi=%h lo=%h lat=%0d",
               g_hi, g_lo, lat, e_hi, e_lo, e_lat);
    end
    a = $urandom;
    b = 32'($urandom_range(1, 1000));
    ref_model(OP_DIVU, a, b, e_hi, e_lo, e_d0, e_lat);
    run_op(OP_DIVU, a, b, 0, g_hi, g_lo, g_d0, lat, busy_ok, add_only, pulse_ok);
    tests_run++;
    if (g_hi !== e_hi || g_lo !== e_lo || g_d0 !== e_d0 || lat != e_lat) begin
      tests_failed++;
      $display("FAIL after_ignore: hi=%h lo=%h div0=%b lat=%0d, required hi=%h lo=%h div0=%b lat=%0d",
               g_hi, g_lo, g_d0, lat, e_hi, e_lo, e_d0, e_lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] g_hi, g_lo;
    logic        g_d0;
    int          lat;
    bit          busy_ok, add_only, pulse_ok, saw_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'h1234_5678;
    bus.src_b = 32'h9ABC_DEF1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done) begin
      tests_failed++;
      $display("FAIL reset_mid_done: done pulse seen after abort, required none");
    end
    run_op(OP_MULTU, 32'd2, 32'd3, 0, g_hi, g_lo, g_d0, lat, busy_ok, add_only, pulse_ok);
    tests_run++;
    if (g_lo !== 32'd6 || g_hi !== 32'h0 || lat != 33) begin
      tests_failed++;
      $display("FAIL reset_mid_restart: hi=%h lo=%h lat=%0d, required 0/6/33", g_hi, g_lo, lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
